if_fetch_stage: RTL and testbench

//  Instruction-fetch stage for the MIPS core. It sits directly upstream of the instruction memory.
//  - Owns the PC and drives the memory word address combinationally.
//  - Captures the returned word into the IF/ID pipeline register for decode.
//  - Resolves next-PC: sequential, jump (from ID), taken beq (from EX), stall and flush.
//  - Detects fetches outside the populated instruction memory and halts on them.

---
 rtl/if_fetch_stage_pkg.sv | 25 ++
 rtl/if_fetch_stage_if.sv | 8 +
 rtl/if_fetch_stage_ifid_reg.sv | 36 +++
 rtl/if_fetch_stage.sv | 81 ++++++++
 tb/tb_if_fetch_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [5:0]  OPC_J        = 6'b000010;
  localparam logic [5:0]  OPC_BEQ      = 6'b000100;

  // Which next-PC source won this cycle, highest priority first.
  typedef enum logic [2:0] {
    SEL_HALT   = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_STALL  = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_FLUSH  = 3'd4,
    SEL_FAULT  = 3'd5,
    SEL_SEQ    = 3'd6
  } pc_sel_e;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus: fetch stage drives the address, memory returns the word combinationally.
interface if_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (output imem_addr, input imem_instr);
  modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: hold beats load; anything else writes a bubble (nop, invalid).
module if_fetch_stage_ifid_reg
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc4_d,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (hold) begin
      instr <= instr;
      pc4   <= pc4;
      valid <= valid;
    end else if (load) begin
      instr <= instr_d;
      pc4   <= pc4_d;
      valid <= 1'b1;
    end else begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC resolution, fetch-fault halt and IF/ID capture.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_VECTOR,
  parameter int          IMEM_WORDS = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jmp,
  input  logic [25:0]      jmp_index,
  if_fetch_stage_if.master imem,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic             fetch_fault,
  output logic [31:0]      fetch_count
);

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  pc_sel_e     sel;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        bad_fetch;

  assign imem.imem_addr = pc;
  assign pc_plus4       = pc + 32'd4;
  assign bad_fetch      = (pc[31:2] >= IMEM_LIMIT) || (pc[1:0] != 2'b00);

  // ifid_valid is the only qualifier downstream: when low, ifid_instr is a nop and ifid_pc4 is 0.
  always_comb begin
    sel = SEL_SEQ;
    if (fetch_fault)            sel = SEL_HALT;
    else if (br_taken)          sel = SEL_BRANCH;
    else if (stall)             sel = SEL_STALL;
    else if (jmp && ifid_valid) sel = SEL_JUMP;
    else if (flush)             sel = SEL_FLUSH;
    else if (bad_fetch)         sel = SEL_FAULT;
  end

  always_comb begin
    pc_next = pc;
    unique case (sel)
      SEL_BRANCH:         pc_next = br_target;
      SEL_JUMP:           pc_next = jump_target(ifid_pc4, jmp_index);
      SEL_FLUSH, SEL_SEQ: pc_next = pc_plus4;
      default:            pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      pc          <= pc_next;
      fetch_fault <= fetch_fault | (sel == SEL_FAULT);
      if (sel == SEL_SEQ) fetch_count <= fetch_count + 32'd1;
    end
  end

  if_fetch_stage_ifid_reg u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (sel == SEL_STALL),
    .load    (sel == SEL_SEQ),
    .instr_d (imem.imem_instr),
    .pc4_d   (pc_plus4),
    .instr   (ifid_instr),
    .pc4     (ifid_pc4),
    .valid   (ifid_valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for the fetch stage against a 21-word program image, with an expected-state queue.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, br_taken, jmp;
  logic [31:0] br_target;
  logic [25:0] jmp_index;
  logic [31:0] pc, ifid_instr, ifid_pc4, fetch_count;
  logic        ifid_valid, fetch_fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
    logic [31:0] count;
  } snap_t;
  localparam int W = $bits(snap_t);

  logic [W-1:0] exp_q[$];
  snap_t        e;
  int           checks = 0;
  int           errors = 0;

  if_fetch_stage_if imem ();

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_index   (jmp_index),
    .imem        (imem.master),
    .pc          (pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] prog_word(input logic [31:0] addr);
    case (addr[31:2])
      30'd0:  return 32'h8C10_0000;
      30'd1:  return 32'h8C11_0004;
      30'd2:  return 32'h0211_9020;
      30'd3:  return 32'hAC12_0008;
      30'd4:  return 32'h1211_0002;
      30'd5:  return 32'h2008_0003;
      30'd6:  return 32'h2008_0001;
      30'd7:  return 32'h2009_0002;
      30'd8:  return 32'h0800_000D;
      30'd9:  return 32'h0800_000D;
      30'd10: return 32'h2008_FFFF;
      30'd11: return 32'h2009_FFFF;
      30'd12: return 32'h0109_5020;
      30'd13: return 32'h3C01_1000;
      30'd14: return 32'h3421_0010;
      30'd15: return 32'h8C22_0000;
      30'd16: return 32'h0043_1820;
      30'd17: return 32'hAC23_0004;
      30'd18: return 32'h1000_FFFF;
      30'd19: return 32'h0000_0020;
      30'd20: return 32'h0800_0014;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign imem.imem_instr = prog_word(imem.imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] t,
                       input logic j, input logic [25:0] ji);
    stall = s; flush = f; br_taken = b; br_target = t; jmp = j; jmp_index = ji;
  endtask

  task automatic tick(input string tag);
    snap_t g;
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check({tag, "_pc"},    pc,                 g.pc);
    check({tag, "_addr"},  imem.imem_addr,     g.pc);
    check({tag, "_instr"}, ifid_instr,         g.instr);
    check({tag, "_pc4"},   ifid_pc4,           g.pc4);
    check({tag, "_valid"}, {31'b0, ifid_valid}, {31'b0, g.valid});
    check({tag, "_fault"}, {31'b0, fetch_fault}, {31'b0, g.fault});
    check({tag, "_count"}, fetch_count,        g.count);
  endtask

  task automatic do_seq(input string tag);
    e.instr = prog_word(e.pc);
    e.pc4   = e.pc + 32'd4;
    e.pc    = e.pc + 32'd4;
    e.valid = 1'b1;
    e.count = e.count + 32'd1;
    exp_q.push_back(e);
    tick(tag);
  endtask

  task automatic do_bubble(input string tag, input logic [31:0] new_pc);
    e.pc    = new_pc;
    e.instr = 32'h0;
    e.pc4   = 32'h0;
    e.valid = 1'b0;
    exp_q.push_back(e);
    tick(tag);
  endtask

  task automatic do_hold(input string tag);
    exp_q.push_back(e);
    tick(tag);
  endtask

  task automatic do_fault(input string tag);
    e.fault = 1'b1;
    do_bubble(tag, e.pc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},    pc,                   32'h0);
    check({tag, "_addr"},  imem.imem_addr,       32'h0);
    check({tag, "_instr"}, ifid_instr,           32'h0);
    check({tag, "_pc4"},   ifid_pc4,             32'h0);
    check({tag, "_valid"}, {31'b0, ifid_valid},  32'h0);
    check({tag, "_fault"}, {31'b0, fetch_fault}, 32'h0);
    check({tag, "_count"}, fetch_count,          32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    e = '0;
    drive(0, 0, 0, 32'h0, 0, 26'd0);
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // Test 1/2: first fetch, steady run, jump from ID
    do_seq("first");
    check("first_word", ifid_instr, 32'h8C10_0000);
    repeat (8) do_seq("run");
    check("at24_instr", ifid_instr, 32'h0800_000D);
    check("at24_pc4",   ifid_pc4,   32'h0000_0024);
    drive(0, 0, 0, 32'h0, 1, 26'd13);
    do_bubble("jump", 32'h34);

    // jmp with an empty IF/ID is ignored; flush bubbles and still advances
    do_seq("jmp_no_valid");
    drive(0, 1, 0, 32'h0, 0, 26'd0);
    do_bubble("flush", 32'h3C);

    // Test 3: stall at pc=0x10, then branch beats stall
    drive(0, 0, 1, 32'h0C, 0, 26'd0);
    do_bubble("br_0c", 32'h0C);
    drive(0, 0, 0, 32'h0, 0, 26'd0);
    do_seq("to10");
    n = $urandom_range(1, 3);
    drive(1, 1, 0, 32'h0, 1, 26'd3);
    repeat (n) do_hold("stall");
    drive(1, 0, 1, 32'h0C, 0, 26'd0);
    do_bubble("stall_br", 32'h0C);

    // Test 4: branch and jump together, branch wins
    drive(0, 0, 0, 32'h0, 0, 26'd0);
    repeat (3) do_seq("pre_bj");
    drive(0, 0, 1, 32'h24, 1, 26'd13);
    do_bubble("br_vs_jmp", 32'h24);
    drive(0, 0, 0, 32'h0, 0, 26'd0);
    do_seq("after_br");
    check("after_br_word", ifid_instr, 32'h0800_000D);

    // Test 5: run off the end of the program
    drive(0, 0, 0, 32'h0, 1, 26'd13);
    do_bubble("jump2", 32'h34);
    drive(0, 0, 0, 32'h0, 0, 26'd0);
    repeat (8) do_seq("tail");
    check("tail_pc", pc, 32'h54);
    do_fault("fault");
    drive(0, 0, 1, 32'h0, 0, 26'd0);
    do_hold("fault_br");
    drive(1, 1, 0, 32'h0, 1, 26'd0);
    do_hold("fault_stall");
    drive(0, 0, 0, 32'h0, 0, 26'd0);
    repeat ($urandom_range(1, 3)) do_hold("fault_idle");

    // Test 6: asynchronous reset mid-cycle during a branch
    drive(0, 0, 1, 32'h40, 0, 26'd0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    drive(0, 0, 0, 32'h0, 0, 26'd0);
    e = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_seq("post_rst");
    check("post_rst_word", ifid_instr, 32'h8C10_0000);

    // misaligned branch target faults on the following fetch
    drive(0, 0, 1, 32'h0E, 0, 26'd0);
    do_bubble("br_mis", 32'h0E);
    drive(0, 0, 0, 32'h0, 0, 26'd0);
    do_fault("misaligned");
    do_hold("mis_hold");

    check("drain", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
